pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stall_counter.sv | 35 +++
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register and its helpers.
package pipe_pkg;

  localparam int unsigned DefCtrlW = 16;
  localparam int unsigned DefDataW = 608;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StEmpty,
    StBusy,
    StFull
  } state_e;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating back-pressure cycle counter with a clear that wins over increment.
module pipe_stall_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional 2-entry skid buffer, flush and stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DefCtrlW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic               accept, consume;

  assign out_valid = (state_q != StEmpty);

  if (SKID != 0) begin : g_skid
    // Decoded from the state register only, so out_ready never reaches in_ready.
    assign in_ready = (state_q != StFull);
  end else begin : g_single
    assign in_ready = !out_valid || out_ready;
  end

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Kill both entries: control becomes a bubble, data is left in place.
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = StBusy;
          end
        end
        StBusy: begin
          if (accept && consume) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept && (SKID != 0)) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = StFull;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (consume) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;

  pipe_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready && !flush),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a single-entry instance vs. a queue model.
module tb_pipe_stage_reg;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 608;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          cnt_clr   [2];
  logic [CW-1:0] in_ctrl   [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] in_data   [2];
  logic [DW-1:0] out_data  [2];
  logic [3:0]    cnt_a;
  logic [15:0]   cnt_z;

  pipe_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .SKID   (1),
    .CNT_W  (4)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_ctrl   (in_ctrl[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_ctrl  (out_ctrl[0]),
    .out_data  (out_data[0]),
    .cnt_clr   (cnt_clr[0]),
    .stall_cnt (cnt_a)
  );

  pipe_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .SKID   (0),
    .CNT_W  (16)
  ) u_dut_z (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_ctrl   (in_ctrl[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_ctrl  (out_ctrl[1]),
    .out_data  (out_data[1]),
    .cnt_clr   (cnt_clr[1]),
    .stall_cnt (cnt_z)
  );

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  ent_t          mq0[$];
  ent_t          mq1[$];
  logic [DW-1:0] mlast [2];
  int unsigned   mcnt  [2];
  bit            z_alt = 1'b1;

  function automatic logic [DW-1:0] rdata();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a FIFO of capacity 2 (skid) or 1 (single) seen through the stage's ports.
  task automatic lane(input int k);
    ent_t          q[$];
    int unsigned   cmax;
    logic          exp_rdy, exp_v, acc, con;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    if (k == 0) begin q = mq0; cmax = 15; end
    else begin q = mq1; cmax = 65535; end
    exp_rdy = (k == 0) ? (q.size() < 2) : (q.size() == 0 || out_ready[k]);
    exp_v   = (q.size() != 0);
    ec      = exp_v ? q[0].c : '0;
    ed      = exp_v ? q[0].d : mlast[k];
    chk($sformatf("L%0d in_ready", k), {639'b0, in_ready[k]}, {639'b0, exp_rdy});
    chk($sformatf("L%0d out_valid", k), {639'b0, out_valid[k]}, {639'b0, exp_v});
    chk($sformatf("L%0d out_ctrl", k), {624'b0, out_ctrl[k]}, {624'b0, ec});
    chk($sformatf("L%0d out_data", k), {32'b0, out_data[k]}, {32'b0, ed});
    chk($sformatf("L%0d stall_cnt", k), (k == 0) ? {636'b0, cnt_a} : {624'b0, cnt_z},
        {608'b0, mcnt[k]});
    mlast[k] = ed;
    if (rst) begin
      q.delete();
      mlast[k] = '0;
      mcnt[k]  = 0;
    end else begin
      if (cnt_clr[k]) mcnt[k] = 0;
      else if (exp_v && !out_ready[k] && !flush[k] && mcnt[k] < cmax) mcnt[k]++;
      if (flush[k]) begin
        q.delete();
      end else begin
        acc = in_valid[k] && exp_rdy;
        con = exp_v && out_ready[k];
        if (con) void'(q.pop_front());
        if (acc) q.push_back({in_ctrl[k], in_data[k]});
      end
    end
    if (k == 0) mq0 = q;
    else mq1 = q;
  endtask

  task automatic cycle();
    if (z_alt) begin
      in_valid[1]  = 1'b1;
      in_ctrl[1]   = CW'($urandom);
      in_data[1]   = rdata();
      out_ready[1] = !out_ready[1];
      flush[1]     = 1'b0;
      cnt_clr[1]   = 1'b0;
    end
    #3;
    lane(0);
    lane(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [CW-1:0] c);
    in_valid[0] = v;
    in_ctrl[0]  = c;
    in_data[0]  = rdata();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; in_valid[k] = 0; out_ready[k] = 0; cnt_clr[k] = 0;
      in_ctrl[k] = '0; in_data[k] = '0; mlast[k] = '0; mcnt[k] = 0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset in_ready", {639'b0, in_ready[0]}, 640'd1);

    // Stream 1..8 with out_ready held high.
    out_ready[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, CW'(i));
      in_data[0] = DW'(i);
      cycle();
      chk("stream latency", {624'b0, out_ctrl[0]}, 640'(i));
    end
    drive_a(1'b0, '0);
    repeat (2) cycle();

    // A then B under back-pressure fills the skid, then drains in order.
    out_ready[0] = 1'b0;
    drive_a(1'b1, 16'h00A0);
    cycle();
    drive_a(1'b1, 16'h00B0);
    cycle();
    drive_a(1'b0, '0);
    chk("full in_ready", {639'b0, in_ready[0]}, 640'd0);
    repeat (3) cycle();
    out_ready[0] = 1'b1;
    repeat (3) cycle();

    // Flush while full, with C offered in the same cycle.
    out_ready[0] = 1'b0;
    drive_a(1'b1, 16'h00D0);
    cycle();
    drive_a(1'b1, 16'h00E0);
    cycle();
    flush[0] = 1'b1;
    drive_a(1'b1, 16'h00C0);
    cycle();
    flush[0] = 1'b0;
    drive_a(1'b0, '0);
    chk("flush out_valid", {639'b0, out_valid[0]}, 640'd0);
    chk("flush out_ctrl", {624'b0, out_ctrl[0]}, 640'd0);
    out_ready[0] = 1'b1;
    repeat (3) cycle();

    // Saturate the 4-bit stall counter, then clear it.
    cnt_clr[0] = 1'b1;
    out_ready[0] = 1'b0;
    drive_a(1'b1, 16'h0050);
    cycle();
    cnt_clr[0] = 1'b0;
    drive_a(1'b0, '0);
    repeat (20) cycle();
    chk("stall saturate", {636'b0, cnt_a}, 640'd15);
    cnt_clr[0] = 1'b1;
    cycle();
    cnt_clr[0] = 1'b0;
    chk("stall clear", {636'b0, cnt_a}, 640'd0);
    out_ready[0] = 1'b1;
    cycle();

    // Randomised traffic on both instances, including rare flush, clear and reset.
    z_alt = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 9) < 6);
        out_ready[k] = ($urandom_range(0, 9) < 6);
        flush[k]     = ($urandom_range(0, 19) == 0);
        cnt_clr[k]   = ($urandom_range(0, 24) == 0);
        in_ctrl[k]   = CW'($urandom);
        in_data[k]   = rdata();
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
